coin_collector: RTL and testbench

COIN_COLLECTOR -- requirements
Module: coin_collector

---
 rtl/coin_collector.sv | 138 +++++++++++++
 tb/tb_coin_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_collector.sv
// coin_collector: accumulates coin credit, latches an item selection and
// presents a stable order to the downstream vend stage, or refunds the
// credit on cancel or inactivity timeout.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active low
//   coin_in      one-cycle coin strobe; coin_val: 00=1, 01=2, 10=4, 11=invalid
//   sel_req      one-cycle select strobe; sel_in item code (000 = no item)
//   cancel       one-cycle cancel strobe
//   order_ack    vend stage consumed the order (honoured only in OFFER)
//   money        registered current credit
//   choice       registered latched item code
//   order_valid  money/choice form a stable order
//   refund       refunded amount, qualified by refund_valid
//   refund_valid one-cycle refund strobe
//   coin_reject  one-cycle strobe: coin sampled last cycle was returned
module coin_collector #(
  parameter int unsigned MAX_CREDIT  = 7,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_in,
  input  logic [1:0] coin_val,
  input  logic       sel_req,
  input  logic [2:0] sel_in,
  input  logic       cancel,
  input  logic       order_ack,
  output logic [2:0] money,
  output logic [2:0] choice,
  output logic       order_valid,
  output logic [2:0] refund,
  output logic       refund_valid,
  output logic       coin_reject
);

  typedef enum logic [1:0] {IDLE, COLLECT, OFFER, REFUND} state_t;

  localparam logic [3:0] MAX_SUM    = 4'(MAX_CREDIT);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state;
  logic [7:0] timer;
  logic [3:0] coin_amt;
  logic [3:0] sum;
  logic       coin_ok;

  // money is the credit register, so in IDLE (credit 0) sum is just the coin
  // value and the same overflow check serves both IDLE and COLLECT.
  always_comb begin
    coin_amt = '0;
    case (coin_val)
      2'b00:   coin_amt = 4'd1;
      2'b01:   coin_amt = 4'd2;
      2'b10:   coin_amt = 4'd4;
      default: coin_amt = '0;
    endcase
    sum     = {1'b0, money} + coin_amt;
    coin_ok = coin_in && (coin_val != 2'b11) && (sum <= MAX_SUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= '0;
      money        <= '0;
      choice       <= '0;
      order_valid  <= 1'b0;
      refund       <= '0;
      refund_valid <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_ok) begin
            money <= sum[2:0];
            timer <= '0;
            state <= COLLECT;
          end else begin
            coin_reject <= coin_in;
          end
        end

        COLLECT: begin
          if (cancel) begin
            coin_reject  <= coin_in;
            refund       <= money;
            refund_valid <= 1'b1;
            state        <= REFUND;
          end else if (sel_req && (sel_in != '0)) begin
            coin_reject <= coin_in;
            choice      <= sel_in;
            order_valid <= 1'b1;
            state       <= OFFER;
          end else if (coin_ok) begin
            money <= sum[2:0];
            timer <= '0;
          end else begin
            // Rejected coins do not restart the inactivity window.
            coin_reject <= coin_in;
            if (timer == TIMER_LAST) begin
              refund       <= money;
              refund_valid <= 1'b1;
              timer        <= '0;
              state        <= REFUND;
            end else begin
              timer <= timer + 8'd1;
            end
          end
        end

        OFFER: begin
          coin_reject <= coin_in;
          if (order_ack) begin
            money       <= '0;
            choice      <= '0;
            order_valid <= 1'b0;
            state       <= IDLE;
          end
        end

        REFUND: begin
          coin_reject  <= coin_in;
          money        <= '0;
          choice       <= '0;
          refund       <= '0;
          refund_valid <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_collector.sv
// Self-checking bench for coin_collector: directed scenarios followed by
// randomized traffic, compared every cycle against a transaction-level model.
module tb_coin_collector;

  localparam int unsigned MAXC = 7;
  localparam int unsigned TO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_in = 1'b0;
  logic [1:0] coin_val = '0;
  logic       sel_req = 1'b0;
  logic [2:0] sel_in = '0;
  logic       cancel = 1'b0;
  logic       order_ack = 1'b0;
  logic [2:0] money;
  logic [2:0] choice;
  logic       order_valid;
  logic [2:0] refund;
  logic       refund_valid;
  logic       coin_reject;

  coin_collector #(.MAX_CREDIT(MAXC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .coin_val(coin_val),
    .sel_req(sel_req), .sel_in(sel_in), .cancel(cancel), .order_ack(order_ack),
    .money(money), .choice(choice), .order_valid(order_valid),
    .refund(refund), .refund_valid(refund_valid), .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: what the customer has paid, what was picked, and how
  // long the machine has sat without a new coin.
  typedef enum int {P_IDLE, P_COLLECT, P_OFFER, P_REFUND} phase_t;
  phase_t m_phase  = P_IDLE;
  int     m_credit = 0;
  int     m_item   = 0;
  int     m_idle   = 0;
  bit     m_rej    = 0;

  task automatic model_reset();
    m_phase = P_IDLE; m_credit = 0; m_item = 0; m_idle = 0; m_rej = 0;
  endtask

  task automatic model_step(input bit c, input int v, input bit s, input int si,
                            input bit cn, input bit ak);
    int amt;
    bit fits;
    amt  = (v == 3) ? 0 : (1 << v);
    fits = (v != 3) && (m_credit + amt <= int'(MAXC));
    m_rej = 0;
    case (m_phase)
      P_IDLE:
        if (c && fits) begin m_credit = amt; m_idle = 0; m_phase = P_COLLECT; end
        else m_rej = c;
      P_COLLECT:
        if (cn) begin m_rej = c; m_phase = P_REFUND; end
        else if (s && si != 0) begin m_rej = c; m_item = si; m_phase = P_OFFER; end
        else if (c && fits) begin m_credit += amt; m_idle = 0; end
        else begin
          m_rej = c;
          m_idle++;
          if (m_idle >= int'(TO)) m_phase = P_REFUND;
        end
      P_OFFER: begin
        m_rej = c;
        if (ak) begin m_credit = 0; m_item = 0; m_phase = P_IDLE; end
      end
      default: begin
        m_rej = c; m_credit = 0; m_item = 0; m_phase = P_IDLE;
      end
    endcase
  endtask

  task automatic compare_all();
    check("money",        8'(money),        8'(m_credit));
    check("choice",       8'(choice),       8'(m_item));
    check("order_valid",  8'(order_valid),  8'(m_phase == P_OFFER));
    check("refund_valid", 8'(refund_valid), 8'(m_phase == P_REFUND));
    check("refund",       8'(refund),       8'((m_phase == P_REFUND) ? m_credit : 0));
    check("coin_reject",  8'(coin_reject),  8'(m_rej));
  endtask

  task automatic cycle(input bit c, input int v, input bit s, input int si,
                       input bit cn, input bit ak);
    @(negedge clk);
    coin_in = c; coin_val = 2'(v); sel_req = s; sel_in = 3'(si);
    cancel = cn; order_ack = ak;
    @(posedge clk);
    model_step(c, v, s, si, cn, ak);
    #1;
    compare_all();
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_money"},  8'(money),        8'd0);
    check({tag, "_choice"}, 8'(choice),       8'd0);
    check({tag, "_ov"},     8'(order_valid),  8'd0);
    check({tag, "_rf"},     8'(refund),       8'd0);
    check({tag, "_rv"},     8'(refund_valid), 8'd0);
    check({tag, "_rej"},    8'(coin_reject),  8'd0);
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    coin_in = 0; sel_req = 0; cancel = 0; order_ack = 0;
    #1;
    check_all_zero(tag);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_rv"}, 8'(refund_valid), 8'd0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1;
    check_all_zero("por");
    #20;
    @(negedge clk);
    rst = 1'b1;

    // Select, cancel and ack in IDLE do nothing.
    cycle(0, 0, 1, 5, 1, 1);
    check("idle_ignore_ov", 8'(order_valid), 8'd0);

    // Coins 4, 2, 1 then an overflowing 1.
    cycle(1, 2, 0, 0, 0, 0); check("seq_m4", 8'(money), 8'd4);
    cycle(1, 1, 0, 0, 0, 0); check("seq_m6", 8'(money), 8'd6);
    cycle(1, 0, 0, 0, 0, 0); check("seq_m7", 8'(money), 8'd7);
    cycle(1, 0, 0, 0, 0, 0); check("seq_rej", 8'(coin_reject), 8'd1);
    check("seq_m7_hold", 8'(money), 8'd7);
    idle_cycle();            check("seq_rej_1cyc", 8'(coin_reject), 8'd0);
    cycle(0, 0, 1, 0, 0, 1); check("sel000_ignored", 8'(order_valid), 8'd0);
    cycle(0, 0, 0, 0, 1, 0);
    idle_cycle();

    // Credit 3, select item 3, hold, then ack.
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 3, 0, 0);
    check("offer_ov", 8'(order_valid), 8'd1);
    check("offer_ch", 8'(choice), 8'd3);
    check("offer_m",  8'(money), 8'd3);
    cycle(0, 0, 1, 6, 1, 0); check("offer_hold_ch", 8'(choice), 8'd3);
    cycle(0, 0, 0, 0, 0, 1);
    check("ack_m", 8'(money), 8'd0);
    check("ack_ch", 8'(choice), 8'd0);

    // Credit 5, cancel and select together -> refund 5.
    cycle(1, 2, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 2, 1, 0);
    check("cancel_rv", 8'(refund_valid), 8'd1);
    check("cancel_rf", 8'(refund), 8'd5);
    check("cancel_ov", 8'(order_valid), 8'd0);
    check("cancel_coin_rej", 8'(coin_reject), 8'd1);
    idle_cycle();
    check("cancel_rv_1cyc", 8'(refund_valid), 8'd0);

    // Credit 2, then timeout after 16 idle cycles.
    cycle(1, 1, 0, 0, 0, 0);
    repeat (TO - 1) idle_cycle();
    check("to_early", 8'(refund_valid), 8'd0);
    idle_cycle();
    check("to_rv", 8'(refund_valid), 8'd1);
    check("to_rf", 8'(refund), 8'd2);
    idle_cycle();

    // Invalid denomination in IDLE and COLLECT.
    cycle(1, 3, 0, 0, 0, 0); check("inv_idle_rej", 8'(coin_reject), 8'd1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 3, 0, 0, 0, 0); check("inv_col_rej", 8'(coin_reject), 8'd1);
    check("inv_col_m", 8'(money), 8'd1);
    cycle(0, 0, 0, 0, 1, 0);
    idle_cycle();

    // Credit 6 in OFFER, coin rejected, then reset mid-OFFER.
    cycle(1, 2, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 5, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("offer_coin_rej", 8'(coin_reject), 8'd1);
    check("offer_coin_m", 8'(money), 8'd6);
    async_reset("rst_offer");

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset("rst_rand");
      end else begin
        cycle(($urandom_range(0, 9) < 3), int'($urandom_range(0, 3)),
              ($urandom_range(0, 19) == 0), int'($urandom_range(0, 7)),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
